ila_capture: RTL
================

# ila_capture

Trigger-and-capture buffer for the on-chip logic analyzer. It sits directly downstream of the DUT and samples the DUT's probe vector on every `clk` once armed. The probe vector is, for example, the 25-bit free-running counter of the blink design. The block keeps a ring of pre-trigger history, fills post-trigger samples after a masked pattern match, and then streams the frozen window out over a valid/ready port to the ILA readout/UART stage.

## Interface
Parameters:
- `SAMPLE_W`, 25: probe vector width.
- `DEPTH`, 256: capture window in samples; power of two, ≥ 4.
- `PRE_TRIG`, 64: samples kept before the trigger sample; 0 ≤ PRE_TRIG < DEPTH.

Ports:
- `clk`  in  1: sample/system clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `sample_in`  in  SAMPLE_W: DUT probe vector, sampled every cycle while capturing.
- `arm`  in  1: start capture; honoured only in IDLE.
- `abort`  in  1: return to IDLE from any state; buffer contents discarded.
- `trig_mask`  in  SAMPLE_W: bits participating in the match.
- `trig_value`  in  SAMPLE_W: compare value.
- `armed`  out  1: high in PREFILL and WAIT_TRIG.
- `triggered`  out  1: high in POSTFILL and READOUT.
- `rd_data`  out  SAMPLE_W: readout sample.
- `rd_valid`  out  1: `rd_data` valid.
- `rd_ready`  in  1: consumer accepts the word when `rd_valid` and `rd_ready` are both high.
- `rd_last`  out  1: marks the DEPTH-th (final) word.

## Operation
- States: IDLE, PREFILL, WAIT_TRIG, POSTFILL, READOUT.
- `match` = (((`sample_in` ^ `trig_value`) & `trig_mask`) == 0).
- IDLE:
  - On `arm`, clear `wr_ptr`, `pre_cnt` and `prev_match`, then go to PREFILL.
  - `arm` in any other state is ignored.
- Write rule: every cycle in PREFILL, WAIT_TRIG and POSTFILL writes `sample_in` to `mem[wr_ptr]` and sets `wr_ptr` ← `wr_ptr`+1 mod DEPTH. The ring wraps freely.
- PREFILL:
  - Counts PRE_TRIG writes, then goes to WAIT_TRIG.
  - No trigger is evaluated in PREFILL.
  - If PRE_TRIG = 0, go to WAIT_TRIG the cycle after `arm`.
- WAIT_TRIG:
  - The first cycle with the trigger condition true stores that sample.
  - That write address is latched as `trig_ptr`.
  - The post-fill counter is loaded with DEPTH−PRE_TRIG−1; then go to POSTFILL.
  - With `trig_mask` = 0, the trigger fires on the first WAIT_TRIG cycle.
- POSTFILL:
  - Writes DEPTH−PRE_TRIG−1 further samples, then goes to READOUT.
  - If DEPTH−PRE_TRIG−1 = 0, go directly to READOUT.
- READOUT:
  - Sampling stops.
  - `rd_ptr` starts at (`trig_ptr` − PRE_TRIG) mod DEPTH and emits exactly DEPTH words in order.
  - Word PRE_TRIG (0-based) is the trigger sample.
  - After the handshake on the `rd_last` word, go to IDLE.
- `abort` takes priority over every other transition. The next state is IDLE and `rd_valid` drops the following cycle.
- The RAM is inferred single-port-write / single-port-read with a registered read.

## Timing
- Reset (`rst`=0 at a clock edge) forces state IDLE, all pointers and counters to 0, and `armed`, `triggered`, `rd_valid` and `rd_last` to 0.
- `rd_data` resets to 0. RAM contents are not reset.
- Reset mid-capture or mid-readout aborts identically; no partial word is presented afterwards.
- The cycle the `arm`=1 edge is seen is IDLE. The first sample written is `sample_in` of the following cycle, and `armed`=1 from that cycle.
- Trigger-to-state: the cycle after the trigger sample is written, the state is POSTFILL and `triggered`=1.
- Readout latency:
  - `rd_valid` first asserts 2 cycles after the last POSTFILL write.
  - The 2 cycles consist of one state-change cycle plus one RAM read.
- Handshake:
  - While `rd_valid`=1 and `rd_ready`=0, `rd_data` and `rd_last` hold stable.
  - With `rd_ready` held at 1, one word transfers per cycle with no bubbles (prefetch).
  - `rd_valid` never deasserts without a transfer, except on abort or reset.
- Total capture: from the first write to the final POSTFILL write is PRE_TRIG + (wait cycles) + DEPTH−PRE_TRIG samples.

## Configuration
- `ILA_EDGE_TRIG_EN` defined: the trigger condition is `match` && !`prev_match`, i.e. a rising edge of the match.
  - `prev_match` is registered on every write cycle, including PREFILL.
  - A pattern already matching when WAIT_TRIG is entered does not trigger until it first goes false and then true again.
- Undefined: the trigger condition is the level `match`, and the `prev_match` register is not built.

## Test plan
- **Level trigger.** `sample_in` = incrementing counter from 0, DEPTH=256, PRE_TRIG=64, mask=0xFF, value=0x80, arm at t0.
  - Trigger on sample 0x080.
  - Readout words 0x040…0x13F: 256 words, word 64 = 0x080, `rd_last` on 0x13F.
- **Ring wrap.** Same setup, value=0x1F0 with mask=0x1FF.
  - The trigger occurs after more than 256 writes.
  - Readout is 0x1B0…0x2AF, contiguous across the wrap.
- **Backpressure.** Toggle `rd_ready` pseudo-randomly.
  - Same 256-word sequence, no drops or duplicates.
  - `rd_data` is stable during every stall.
- **Mask zero.** mask=0, PRE_TRIG=0, arm.
  - Trigger on the first sample.
  - `rd_valid` rises exactly 2 cycles after the 256th write.
- **Abort/reset.** Assert `abort` in POSTFILL, then `rst`=0 in READOUT of a second run.
  - Both return to IDLE with all outputs 0 next cycle.
  - A subsequent arm captures correctly.
- **Edge trigger** (`ILA_EDGE_TRIG_EN`). `sample_in` constant 0x5 during PREFILL and WAIT_TRIG, value=0x5, mask=all.
  - No trigger.
  - Drive 0x6 then 0x5: the trigger fires on the second 0x5 sample.

Source files
------------

// File: rtl/ila_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ila_capture - logic-analyzer trigger/capture ring with valid/ready readout.
// Build option: ILA_EDGE_TRIG_EN triggers on the rising edge of the match.
// Rev 1.0
// ---------------------------------------------------------------------------
module ila_capture #(
  parameter int SAMPLE_W = 25,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                arm,
  input  logic                abort,
  input  logic [SAMPLE_W-1:0] trig_mask,
  input  logic [SAMPLE_W-1:0] trig_value,
  output logic                armed,
  output logic                triggered,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_last
);
  localparam int AW         = $clog2(DEPTH);
  localparam int CW         = AW + 1;
  localparam int PRE_LAST_I = (PRE_TRIG == 0) ? 0 : PRE_TRIG - 1;
  localparam logic [AW-1:0] PRE_LAST = AW'(PRE_LAST_I);
  localparam logic [AW-1:0] PRE_OFS  = AW'(PRE_TRIG);
  localparam logic [AW-1:0] POST_LEN = AW'(DEPTH - PRE_TRIG - 1);
  localparam logic [CW-1:0] WORDS    = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PREFILL   = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POSTFILL  = 3'd3,
    S_READOUT   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       pre_cnt_q, pre_cnt_d;
  logic [AW-1:0]       post_cnt_q, post_cnt_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       rd_cnt_q, rd_cnt_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic                armed_q, armed_d;
  logic                triggered_q, triggered_d;
  logic [SAMPLE_W-1:0] rd_data_q;
  logic                wr_en, rd_en;
  logic                match, trig_hit;

  logic [SAMPLE_W-1:0] mem [DEPTH];

  assign match = ((sample_in ^ trig_value) & trig_mask) == '0;

`ifdef ILA_EDGE_TRIG_EN
  logic prev_match_q, prev_match_d;
  assign trig_hit = match && !prev_match_q;
`else
  assign trig_hit = match;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
`ifdef ILA_EDGE_TRIG_EN
    prev_match_d = prev_match_q;
`endif
    wr_en = 1'b0;
    rd_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          wr_ptr_d  = '0;
          pre_cnt_d = '0;
          rd_cnt_d  = '0;
`ifdef ILA_EDGE_TRIG_EN
          prev_match_d = 1'b0;
`endif
          state_d = (PRE_TRIG == 0) ? S_WAIT_TRIG : S_PREFILL;
        end
      end
      S_PREFILL: begin
        wr_en     = 1'b1;
        pre_cnt_d = pre_cnt_q + AW'(1);
        if (pre_cnt_q == PRE_LAST) state_d = S_WAIT_TRIG;
      end
      S_WAIT_TRIG: begin
        wr_en = 1'b1;
        if (trig_hit) begin
          // Readout starts PRE_TRIG slots behind the trigger sample's address.
          rd_ptr_d   = wr_ptr_q - PRE_OFS;
          post_cnt_d = POST_LEN;
          rd_cnt_d   = '0;
          state_d    = (POST_LEN == '0) ? S_READOUT : S_POSTFILL;
        end
      end
      S_POSTFILL: begin
        wr_en      = 1'b1;
        post_cnt_d = post_cnt_q - AW'(1);
        if (post_cnt_q == AW'(1)) state_d = S_READOUT;
      end
      S_READOUT: begin
        // Fetch the next word whenever the output slot is empty or draining.
        rd_en = (rd_cnt_q != WORDS) && (!rd_valid_q || rd_ready);
        if (rd_en) begin
          rd_ptr_d   = rd_ptr_q + AW'(1);
          rd_cnt_d   = rd_cnt_q + CW'(1);
          rd_valid_d = 1'b1;
          rd_last_d  = (rd_cnt_q == LAST_IDX);
        end else if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (rd_last_q) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
`ifdef ILA_EDGE_TRIG_EN
      prev_match_d = match;
`endif
    end

    armed_d     = (state_d == S_PREFILL) || (state_d == S_WAIT_TRIG);
    triggered_d = (state_d == S_POSTFILL) || (state_d == S_READOUT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
`ifdef ILA_EDGE_TRIG_EN
      prev_match_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      armed_q     <= armed_d;
      triggered_q <= triggered_d;
`ifdef ILA_EDGE_TRIG_EN
      prev_match_q <= prev_match_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample_in;
  end

  // Registered RAM read doubles as the output holding register.
  always_ff @(posedge clk) begin
    if (!rst || abort) rd_data_q <= '0;
    else if (rd_en)    rd_data_q <= mem[rd_ptr_q];
  end

  assign armed     = armed_q;
  assign triggered = triggered_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_data   = rd_data_q;

endmodule
`default_nettype wire
